// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Handshake/payload bundle for pipe_stage_reg. Optional counters
//               appear when PIPE_STAGE_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [1:0]        count_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  accept_cnt_o;
`endif

    modport slave (
        input  flush_i, valid_i, data_i, ctrl_i, ready_i,
`ifdef PIPE_STAGE_PERF_EN
        output stall_cnt_o, accept_cnt_o,
`endif
        output ready_o, valid_o, data_o, ctrl_o, count_o
    );

    modport master (
        output flush_i, valid_i, data_i, ctrl_i, ready_i,
`ifdef PIPE_STAGE_PERF_EN
        input  stall_cnt_o, accept_cnt_o,
`endif
        input  ready_o, valid_o, data_o, ctrl_o, count_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : 2-entry in-order pipeline register (head + skid) with
//               registered ready; optional counters under PIPE_STAGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    pipe_stage_reg_if.slave bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_ready;
    logic w_valid;
    logic w_in;
    logic w_out;
    logic w_head_ld;
    logic w_head_from_skid;
    logic w_skid_ld;

    // Ready never looks at ready_i, so the upstream path stays register-bounded.
    assign w_ready = (r_state != S_FULL) && !rst_i;
    assign w_valid = (r_state != S_EMPTY);
    assign w_in    = bus.valid_i && w_ready;
    assign w_out   = w_valid && bus.ready_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_head_ld        = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        if (bus.flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in) begin
                        w_state_nxt = S_ONE;
                        w_head_ld   = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in && w_out) begin
                        w_head_ld = 1'b1;
                    end else if (w_in) begin
                        w_state_nxt = S_FULL;
                        w_skid_ld   = 1'b1;
                    end else if (w_out) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out) begin
                        w_state_nxt      = S_ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_EMPTY;
            r_head_data <= '0;
            r_head_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_head_ld) begin
                r_head_data <= bus.data_i;
                r_head_ctrl <= bus.ctrl_i;
            end else if (w_head_from_skid) begin
                r_head_data <= r_skid_data;
                r_head_ctrl <= r_skid_ctrl;
            end
            if (w_skid_ld) begin
                r_skid_data <= bus.data_i;
                r_skid_ctrl <= bus.ctrl_i;
            end
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = w_valid;
    assign bus.data_o  = r_head_data;
    assign bus.ctrl_o  = w_valid ? r_head_ctrl : '0;
    assign bus.count_o = r_state;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_accept_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_accept_cnt <= '0;
        end else begin
            if (w_valid && !bus.ready_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_in && (r_accept_cnt != '1)) begin
                r_accept_cnt <= r_accept_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.accept_cnt_o = r_accept_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed vector table, queue reference model with random
//               traffic, and counter sequences when PIPE_STAGE_PERF_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;
    localparam int DATA_W  = 128;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;

    typedef struct {
        logic              r, f, v;
        logic [DATA_W-1:0] d;
        logic              rd;
        logic              chk;
        logic [1:0]        ecnt;
        logic              ev, er;
        logic [DATA_W-1:0] ed;
    } vec_t;

    ent_t              q[$];
    logic [DATA_W-1:0] m_last;
    int                m_stall, m_accept;
    bit                m_known = 1'b0;
    int                n_chk = 0, n_pass = 0;
    vec_t              vq[$];

    function automatic logic [CTRL_W-1:0] cf(input logic [DATA_W-1:0] d);
        return d[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, f, v, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic rd);
        rst         = r;
        bus.flush_i = f;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ctrl_i  = c;
        bus.ready_i = rd;
    endtask

    task automatic model_check();
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic [CTRL_W-1:0] ec;
        if (!m_known) return;
        ev = (q.size() > 0);
        ed = ev ? q[0].d : m_last;
        ec = ev ? q[0].c : '0;
        chk("model_count", 128'(bus.count_o), 128'(q.size()));
        chk("model_valid", 128'(bus.valid_o), 128'(ev));
        chk("model_ready", 128'(bus.ready_o), 128'((q.size() < 2) && !rst));
        chk("model_data",  128'(bus.data_o),  128'(ed));
        chk("model_ctrl",  128'(bus.ctrl_o),  128'(ec));
`ifdef PIPE_STAGE_PERF_EN
        chk("model_stall_cnt",  128'(bus.stall_cnt_o),  128'(m_stall));
        chk("model_accept_cnt", 128'(bus.accept_cnt_o), 128'(m_accept));
`endif
    endtask

    // Reference behaviour: a FIFO of at most two entries, flushed on demand.
    task automatic model_step();
        logic vo, ro, tin, tout;
        vo   = (q.size() > 0);
        ro   = (q.size() < 2) && !rst;
        tin  = bus.valid_i && ro;
        tout = vo && bus.ready_i;
        if (rst) begin
            q.delete();
            m_last   = '0;
            m_stall  = 0;
            m_accept = 0;
            m_known  = 1'b1;
        end else if (m_known) begin
            if (vo && !bus.ready_i && m_stall < CNT_MAX) m_stall++;
            if (tin && m_accept < CNT_MAX) m_accept++;
            if (bus.flush_i) q.delete();
            else begin
                if (tout) void'(q.pop_front());
                if (tin) q.push_back('{d: bus.data_i, c: bus.ctrl_i});
            end
            if (q.size() > 0) m_last = q[0].d;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cycle(input logic r, f, v, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic rd);
        drive(r, f, v, d, c, rd);
        #1;
        model_check();
        advance();
    endtask

    task automatic add(input logic r, f, v, input logic [DATA_W-1:0] d, input logic rd,
                       input logic chk_en, input logic [1:0] ecnt,
                       input logic ev, er, input logic [DATA_W-1:0] ed);
        vq.push_back('{r: r, f: f, v: v, d: d, rd: rd, chk: chk_en,
                       ecnt: ecnt, ev: ev, er: er, ed: ed});
    endtask

    initial begin
        //   rst flsh vld data    rdy   chk cnt vld rdy data
        add(1, 0, 1, 'h99, 0,   0, 0, 0, 0, 'h0);
        add(1, 0, 1, 'h99, 0,   1, 0, 0, 0, 'h0);
        add(0, 0, 0, 'h0,  1,   1, 0, 0, 1, 'h0);
        add(0, 0, 1, 'h11, 1,   1, 0, 0, 1, 'h0);
        add(0, 0, 1, 'h12, 1,   1, 1, 1, 1, 'h11);
        add(0, 0, 1, 'h13, 1,   1, 1, 1, 1, 'h12);
        add(0, 0, 1, 'h14, 1,   1, 1, 1, 1, 'h13);
        add(0, 0, 0, 'h0,  1,   1, 1, 1, 1, 'h14);
        add(0, 0, 0, 'h0,  0,   1, 0, 0, 1, 'h14);
        add(0, 0, 1, 'hA,  0,   1, 0, 0, 1, 'h14);
        add(0, 0, 1, 'hB,  0,   1, 1, 1, 1, 'hA);
        add(0, 0, 1, 'hC,  0,   1, 2, 1, 0, 'hA);
        add(0, 0, 1, 'hC,  0,   1, 2, 1, 0, 'hA);
        add(0, 0, 1, 'hC,  1,   1, 2, 1, 0, 'hA);
        add(0, 0, 1, 'hC,  1,   1, 1, 1, 1, 'hB);
        add(0, 0, 0, 'h0,  1,   1, 1, 1, 1, 'hC);
        add(0, 0, 0, 'h0,  0,   1, 0, 0, 1, 'hC);
        add(0, 0, 1, 'h21, 0,   1, 0, 0, 1, 'hC);
        add(0, 0, 1, 'h22, 0,   1, 1, 1, 1, 'h21);
        add(0, 1, 1, 'hD,  0,   1, 2, 1, 0, 'h21);
        add(0, 0, 0, 'h0,  1,   1, 0, 0, 1, 'h21);
        add(0, 0, 1, 'h31, 0,   1, 0, 0, 1, 'h21);
        add(0, 1, 1, 'h32, 1,   1, 1, 1, 1, 'h31);
        add(0, 0, 0, 'h0,  1,   1, 0, 0, 1, 'h31);
        add(0, 0, 1, 'h01, 0,   1, 0, 0, 1, 'h31);
        add(0, 0, 1, 'h02, 1,   1, 1, 1, 1, 'h01);
        add(0, 0, 0, 'h0,  0,   1, 1, 1, 1, 'h02);
        add(1, 0, 1, 'h77, 1,   1, 1, 1, 0, 'h02);
        add(0, 0, 0, 'h0,  0,   1, 0, 0, 1, 'h0);

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].f, vq[i].v, vq[i].d, cf(vq[i].d), vq[i].rd);
            #1;
            model_check();
            if (vq[i].chk) begin
                chk($sformatf("vec%0d_count", i), 128'(bus.count_o), 128'(vq[i].ecnt));
                chk($sformatf("vec%0d_valid", i), 128'(bus.valid_o), 128'(vq[i].ev));
                chk($sformatf("vec%0d_ready", i), 128'(bus.ready_o), 128'(vq[i].er));
                chk($sformatf("vec%0d_data", i),  128'(bus.data_o),  128'(vq[i].ed));
                chk($sformatf("vec%0d_ctrl", i),  128'(bus.ctrl_o),
                    vq[i].ev ? 128'(cf(vq[i].ed)) : 128'(0));
            end
            advance();
        end

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0,
                  {$urandom, $urandom, $urandom, $urandom},
                  CTRL_W'($urandom), $urandom_range(0, 2) != 0);
        end

`ifdef PIPE_STAGE_PERF_EN
        cycle(1, 0, 0, '0, '0, 0);
        cycle(0, 0, 1, 'h40, cf('h40), 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, '0, 0);
        cycle(0, 0, 1, 'h41, cf('h41), 1);
        cycle(0, 0, 1, 'h42, cf('h42), 1);
        drive(0, 0, 0, '0, '0, 0);
        #1;
        chk("perf_stall_5",  128'(bus.stall_cnt_o),  128'(5));
        chk("perf_accept_3", 128'(bus.accept_cnt_o), 128'(3));
        advance();
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, '0, 0);
        #1;
        chk("perf_stall_sat", 128'(bus.stall_cnt_o), 128'(CNT_MAX));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128, width of the datapath payload (pc, ALU result, vector ALU result, store data).
REQ-002 Parameter CTRL_W, default 8, width of the control bundle (RegWrite, MemToReg, MemRead, MemWrite, zero, spare).
REQ-003 Parameter CNT_W, default 16, width of the performance counters.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous, active-high.
REQ-006 flush_i  input  1  discards all buffered entries (branch mispredict / exception).
REQ-007 valid_i  input  1  upstream stage presents an entry.
REQ-008 ready_o  output  1  block can accept an entry this cycle.
REQ-009 data_i  input  DATA_W  upstream payload.
REQ-010 ctrl_i  input  CTRL_W  upstream control bundle.
REQ-011 valid_o  output  1  head entry is valid.
REQ-012 ready_i  input  1  downstream stage accepts the head entry.
REQ-013 data_o  output  DATA_W  head payload.
REQ-014 ctrl_o  output  CTRL_W  head control bundle; all-zero whenever valid_o=0 (bubble).
REQ-015 count_o  output  2  occupancy, 0..2.
REQ-016 stall_cnt_o, accept_cnt_o  output  CNT_W  each; present only with PIPE_STAGE_PERF_EN.

Function
REQ-017 The block SHALL be a 2-entry in-order buffer (head register plus skid register) with states EMPTY (count 0), ONE (count 1) and FULL (count 2).
REQ-018 An input transfer SHALL occur when valid_i && ready_o, and an output transfer when valid_o && ready_i.
REQ-019 ready_o SHALL be driven only from registered state: 1 when count<2 and rst_i=0, and 0 otherwise; it SHALL NOT depend combinationally on ready_i.
REQ-020 valid_o SHALL be 1 exactly when count>=1.
REQ-021 Latency SHALL be 1 cycle: an entry accepted in EMPTY SHALL appear on data_o/ctrl_o with valid_o=1 on the next cycle.
REQ-022 EMPTY: input only -> ONE; no transfer -> EMPTY.
REQ-023 ONE: input only -> FULL, with the entry written to the skid register; output only -> EMPTY; both -> stay ONE with the head replaced by the new entry.
REQ-024 FULL: output -> ONE, with the skid entry moved to the head; no output -> stay FULL; no input is possible because ready_o=0.
REQ-025 Entries SHALL leave in acceptance order, and no entry SHALL be lost or duplicated.
REQ-026 While valid_o=0, data_o SHALL hold its last value and ctrl_o SHALL be zero.
REQ-027 flush_i=1 SHALL set count to 0 on the next edge and SHALL discard any simultaneous input transfer; flush_i has priority over valid_i and ready_i.
REQ-028 The output transfer presented in the cycle flush_i=1 is asserted SHALL still count as consumed by downstream.

Reset
REQ-029 While rst_i=1 at a clock edge, the next state SHALL be: count_o=0, valid_o=0, ready_o=0, data_o=0, ctrl_o=0, with counters zeroed.
REQ-030 Reset SHALL take priority over flush_i and all transfers; an in-flight entry is dropped.
REQ-031 ready_o SHALL return to 1 in the first cycle with rst_i=0.

Configuration
REQ-032 Macro PIPE_STAGE_PERF_EN defined: stall_cnt_o SHALL increment each cycle valid_o && !ready_i, and accept_cnt_o SHALL increment each input transfer; both SHALL saturate at all-ones and clear on rst_i.
REQ-033 PIPE_STAGE_PERF_EN undefined: both ports and their counters SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Reset: hold rst_i 2 cycles with valid_i=1 -> valid_o=0, ctrl_o=0, data_o=0, ready_o=0; ready_o=1 on the first cycle after release.
REQ-035 Streaming: ready_i=1, push A=0x11..0x14 back-to-back -> data_o shows them in order, each 1 cycle after acceptance, count_o stays at 1 and ready_o stays 1.
REQ-036 Backpressure: ready_i=0, push 0xA, 0xB, 0xC -> 0xC is not accepted (ready_o=0 at count 2); releasing ready_i -> 0xA, 0xB, then 0xC delivered in order.
REQ-037 Flush: count 2, then flush_i=1 with valid_i=1 and data 0xD -> next cycle count_o=0, valid_o=0, ctrl_o=0, and 0xD is never output.
REQ-038 Simultaneous in/out at ONE: head 0x1, push 0x2 with ready_i=1 -> next cycle data_o=0x2 and count_o=1.
REQ-039 Perf (macro on): 5 stall cycles, then 3 accepts -> stall_cnt_o=5, accept_cnt_o=3; forced counter at all-ones stays at all-ones.
